// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: a little-endian, byte-addressable memory window with optional
// fixed wait states per accepted transfer and two-cycle ERROR responses.
module ahb_sram_slave #(
    parameter logic [31:0] START_ADDR     = 32'h0,
    parameter int unsigned DEPTH_IN_BYTES = 32'h100,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYOUT
);

    localparam int unsigned DepthWords = DEPTH_IN_BYTES / 4;
    localparam int unsigned IdxW       = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam logic [32:0] LastAddr   = {1'b0, START_ADDR} + 33'(DEPTH_IN_BYTES) - 33'd1;
    localparam logic [1:0]  WaitLast   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;

    logic        can_accept;
    logic        accept;
    logic [2:0]  size_bytes;
    logic [32:0] start_off;
    logic [32:0] end_addr;
    logic        misaligned;
    logic        addr_err;
    logic [31:0] mem_off;
    logic [IdxW-1:0] word_idx;
    logic [3:0]  byte_en;

    logic [31:0] mem [DepthWords];

    // ------------------------------------------------------------------
    // Address-phase decode and error check
    // ------------------------------------------------------------------
    assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];

    always_comb begin
        size_bytes = 3'd4;
        case (HSIZE)
            3'd0:    size_bytes = 3'd1;
            3'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    // Borrow out of the subtraction flags an address below the window.
    assign start_off  = {1'b0, HADDR} - {1'b0, START_ADDR};
    assign end_addr   = {1'b0, HADDR} + {30'd0, size_bytes} - 33'd1;
    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign addr_err   = start_off[32] || (end_addr > LastAddr) || (HSIZE > 3'd2) || misaligned;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StIdle;
            wait_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        HREADYOUT  = 1'b1;
        HRESP      = 2'b00;

        if (accept) begin
            addr_d     = HADDR;
            write_d    = HWRITE;
            size_d     = HSIZE[1:0];
            wait_cnt_d = 2'd0;
        end

        case (state_q)
            StIdle, StData: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d = StErr1;
                    end else begin
                        state_d = (WAIT_STATES > 0) ? StWait : StData;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                HREADYOUT = 1'b0;
                if (wait_cnt_q == WaitLast) begin
                    state_d = StData;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP = 2'b01;
                if (accept) begin
                    if (addr_err) begin
                        state_d = StErr1;
                    end else begin
                        state_d = (WAIT_STATES > 0) ? StWait : StData;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory array and data path
    // ------------------------------------------------------------------
    assign mem_off  = addr_q - START_ADDR;
    assign word_idx = mem_off[IdxW+1:2];

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en[addr_q[1:0]] = 1'b1;
            2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Write lands at the edge closing the DATA cycle, so a read data phase that
    // follows directly already sees the updated word.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state_q == StData) && write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (byte_en[n]) begin
                    mem[word_idx][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

    assign HRDATA = ((state_q == StData) && !write_q) ? mem[word_idx] : 32'd0;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0], start_off, mem_off};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three slaves (0, 2 and 3 wait states) behind a small decoder and
// read mux, driven by a pipelined master and checked every cycle against a byte-level model.
`timescale 1ns/1ps
module tb_ahb_sram_slave;

    localparam int          NS    = 3;
    localparam logic [31:0] START = 32'h0;
    localparam int unsigned DEPTH = 256;

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
    endfunction

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        sel_en = 1'b0;
    int          sel_slv = 0;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [NS-1:0] hsel;
    logic [NS-1:0] hro;
    logic [1:0]  hresp_s [NS];
    logic [31:0] hrdata_s [NS];
    logic        hready;
    logic [31:0] hrdata_bus;
    int          dp_sel = -1;

    int n_tests = 0;
    int n_fail  = 0;
    int low_cnt [NS];
    int err_cnt [NS];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign hsel[g] = sel_en && (sel_slv == g);
        ahb_sram_slave #(
            .START_ADDR    (START),
            .DEPTH_IN_BYTES(DEPTH),
            .WAIT_STATES   ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .HCLK     (HCLK),
            .HRESET   (HRESET),
            .HSEL     (hsel[g]),
            .HADDR    (haddr),
            .HTRANS   (htrans),
            .HWRITE   (hwrite),
            .HSIZE    (hsize),
            .HBURST   (hburst),
            .HWDATA   (hwdata),
            .HREADY   (hready),
            .HRDATA   (hrdata_s[g]),
            .HRESP    (hresp_s[g]),
            .HREADYOUT(hro[g])
        );
    end

    // Interconnect: data-phase owner selects HREADY and HRDATA.
    always_comb begin
        hready     = 1'b1;
        hrdata_bus = 32'd0;
        for (int s = 0; s < NS; s++) begin
            if (dp_sel == s) begin
                hready     = hro[s];
                hrdata_bus = hrdata_s[s];
            end
        end
    end

    always @(posedge HCLK) begin
        if (HRESET) dp_sel <= -1;
        else if (hready) dp_sel <= sel_en ? sel_slv : -1;
    end

    // ------------------------------------------------------------------
    // Reference model: byte memory plus one pending data phase per slave
    // ------------------------------------------------------------------
    logic [7:0]  mm [NS][DEPTH];
    bit          pend [NS];
    bit          perr [NS];
    bit          pwrite [NS];
    int          pcnt [NS];
    logic [31:0] paddr [NS];
    logic [2:0]  psize [NS];
    bit          model_on = 1'b0;

    function automatic int plen(input int s);
        return perr[s] ? 2 : ws_of(s) + 1;
    endfunction

    function automatic bit exp_ready(input int s);
        return !pend[s] || (pcnt[s] == plen(s) - 1);
    endfunction

    function automatic logic [31:0] mword(input int s, input logic [31:0] a);
        int b;
        b = int'(a - START) & ~3;
        return {mm[s][b+3], mm[s][b+2], mm[s][b+1], mm[s][b]};
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        longint first, last, lo, hi;
        int nb;
        if (sz > 3'd2) return 1'b1;
        nb = 1 << sz;
        if ((a % nb) != 0) return 1'b1;
        first = longint'(a);
        last  = first + nb - 1;
        lo    = longint'(START);
        hi    = lo + longint'(DEPTH) - 1;
        return (first < lo) || (last > hi);
    endfunction

    task automatic model_step();
        bit bus_rdy;
        int b;
        if (HRESET) begin
            for (int s = 0; s < NS; s++) pend[s] = 1'b0;
            model_on = 1'b1;
            return;
        end
        bus_rdy = 1'b1;
        for (int s = 0; s < NS; s++) if (pend[s]) bus_rdy = exp_ready(s);
        for (int s = 0; s < NS; s++) begin
            if (pend[s]) begin
                if (pcnt[s] == plen(s) - 1) begin
                    if (pwrite[s] && !perr[s]) begin
                        for (int k = 0; k < (1 << psize[s]); k++) begin
                            b = int'(paddr[s] - START) + k;
                            mm[s][b] = hwdata[8*(b%4) +: 8];
                        end
                    end
                    pend[s] = 1'b0;
                end else begin
                    pcnt[s]++;
                end
            end
        end
        if (bus_rdy && sel_en && htrans[1]) begin
            pend[sel_slv]   = 1'b1;
            pcnt[sel_slv]   = 0;
            perr[sel_slv]   = is_err(haddr, hsize);
            pwrite[sel_slv] = hwrite;
            paddr[sel_slv]  = haddr;
            psize[sel_slv]  = hsize;
        end
    endtask

    initial begin
        forever begin
            @(posedge HCLK);
            model_step();
        end
    end

    // Per-cycle compare of every slave against the model
    initial begin
        logic        er;
        logic [1:0]  eresp;
        logic [31:0] ed;
        forever begin
            @(negedge HCLK);
            if (model_on) begin
                for (int s = 0; s < NS; s++) begin
                    er    = exp_ready(s);
                    eresp = (pend[s] && perr[s]) ? 2'd1 : 2'd0;
                    ed    = (pend[s] && !perr[s] && !pwrite[s] && er) ? mword(s, paddr[s]) : 32'd0;
                    n_tests++;
                    if (hro[s] !== er || hresp_s[s] !== eresp || hrdata_s[s] !== ed) begin
                        n_fail++;
                        $display("FAIL s%0d outputs @%0t: got ready=%0b resp=%0d rdata=%08h, required ready=%0b resp=%0d rdata=%08h",
                                 s, $time, hro[s], hresp_s[s], hrdata_s[s], er, eresp, ed);
                    end
                    if (hro[s] == 1'b0) low_cnt[s]++;
                    if (hresp_s[s] == 2'd1) err_cnt[s]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipelined master
    // ------------------------------------------------------------------
    typedef struct {
        bit          sel;
        int          slv;
        logic [1:0]  trans;
        bit          write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       seq_q [$];
    logic [31:0] rd_q [$];

    function automatic xfer_t idle_x();
        xfer_t x;
        x.sel = 1'b0; x.slv = 0; x.trans = 2'd0; x.write = 1'b0;
        x.size = 3'd0; x.burst = 3'd0; x.addr = 32'd0; x.wdata = 32'd0;
        return x;
    endfunction

    task automatic xf(input int slv, input bit write, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size = 3'd2,
                      input logic [1:0] trans = 2'd2, input logic [2:0] burst = 3'd0);
        xfer_t x;
        x.sel = 1'b1; x.slv = slv; x.trans = trans; x.write = write;
        x.size = size; x.burst = burst; x.addr = addr; x.wdata = wdata;
        seq_q.push_back(x);
    endtask

    task automatic drive_ap(input xfer_t x);
        sel_en  = x.sel;
        sel_slv = x.slv;
        htrans  = x.trans;
        hwrite  = x.write;
        hsize   = x.size;
        hburst  = x.burst;
        haddr   = x.addr;
    endtask

    task automatic run_seq();
        xfer_t       ap, dp;
        bit          dp_v, rdy;
        logic [31:0] rdat;
        int          guard;
        dp_v = 1'b0;
        dp   = idle_x();
        while (seq_q.size() > 0 || dp_v) begin
            ap = (seq_q.size() > 0) ? seq_q[0] : idle_x();
            drive_ap(ap);
            guard = 0;
            do begin
                @(negedge HCLK);
                rdy  = hready;
                rdat = hrdata_bus;
                @(posedge HCLK);
                #1;
                guard++;
            end while (!rdy && guard < 40);
            if (!rdy) begin
                n_tests++;
                n_fail++;
                $display("FAIL bus stall: hready=%0b after 40 cycles, required 1", rdy);
            end
            if (dp_v && !dp.write) rd_q.push_back(rdat);
            dp     = (seq_q.size() > 0) ? seq_q.pop_front() : idle_x();
            dp_v   = dp.sel && dp.trans[1];
            hwdata = dp.write ? dp.wdata : $urandom();
        end
        drive_ap(idle_x());
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        xfer_t       x;
        logic [31:0] a;
        int          t;
        for (int s = 0; s < NS; s++) begin
            low_cnt[s] = 0;
            err_cnt[s] = 0;
        end
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        for (int s = 0; s < NS; s++) begin
            check32($sformatf("reset s%0d hreadyout", s), 32'(hro[s]), 32'd1);
            check32($sformatf("reset s%0d hresp", s), 32'(hresp_s[s]), 32'd0);
            check32($sformatf("reset s%0d hrdata", s), hrdata_s[s], 32'd0);
        end
        @(posedge HCLK);
        #1;

        // Give every model byte a known value
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < DEPTH / 4; w++) xf(s, 1'b1, 32'(4 * w), $urandom());
        run_seq();

        // Word write then read, zero wait
        rd_q.delete();
        low_cnt[0] = 0;
        xf(0, 1'b1, 32'h10, 32'hDEADBEEF);
        seq_q.push_back(idle_x());
        xf(0, 1'b0, 32'h10, 32'h0);
        run_seq();
        check32("word rd 0x10", rd_q[0], 32'hDEADBEEF);
        check32("s0 no wait cycles", low_cnt[0], 0);

        // Mixed-size writes merge into one word
        rd_q.delete();
        xf(0, 1'b1, 32'h10, 32'h11223344);
        xf(0, 1'b1, 32'h13, 32'hA5000000, 3'd0);
        xf(0, 1'b1, 32'h10, 32'h0000BEEF, 3'd1);
        xf(0, 1'b0, 32'h10, 32'h0);
        run_seq();
        check32("merged rd 0x10", rd_q[0], 32'hA522BEEF);

        // Pipelined write then read of the same word
        rd_q.delete();
        xf(0, 1'b1, 32'h20, 32'hCAFEF00D);
        xf(0, 1'b0, 32'h20, 32'h0);
        run_seq();
        check32("pipelined rd 0x20", rd_q[0], 32'hCAFEF00D);

        // INCR4 bursts on the two-wait-state slave
        rd_q.delete();
        low_cnt[1] = 0;
        for (int i = 0; i < 4; i++)
            xf(1, 1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 3'd2, (i == 0) ? 2'd2 : 2'd3, 3'd3);
        run_seq();
        check32("incr4 wr wait cycles", low_cnt[1], 8);
        low_cnt[1] = 0;
        for (int i = 0; i < 4; i++)
            xf(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 3'd2, (i == 0) ? 2'd2 : 2'd3, 3'd3);
        run_seq();
        check32("incr4 rd wait cycles", low_cnt[1], 8);
        for (int i = 0; i < 4; i++) check32($sformatf("incr4 rd beat %0d", i), rd_q[i], 32'(i + 1));

        // Error responses leave memory untouched
        xf(0, 1'b1, 32'hFC, 32'h0BADF00D);
        run_seq();
        err_cnt[0] = 0;
        low_cnt[0] = 0;
        xf(0, 1'b1, 32'h100, 32'hFFFFFFFF);
        xf(0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'd1);
        xf(0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'd3);
        run_seq();
        check32("error resp cycles", err_cnt[0], 6);
        check32("error ready-low cycles", low_cnt[0], 3);
        rd_q.delete();
        xf(0, 1'b0, 32'hFC, 32'h0);
        xf(0, 1'b0, 32'h10, 32'h0);
        run_seq();
        check32("rd 0xFC after errors", rd_q[0], 32'h0BADF00D);
        check32("rd 0x10 after errors", rd_q[1], 32'hA522BEEF);

        // Reset in the second wait cycle of a write abandons it
        xf(2, 1'b1, 32'h30, 32'h30303030);
        run_seq();
        sel_en = 1'b1; sel_slv = 2; htrans = 2'd2; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h30; hburst = 3'd0;
        @(posedge HCLK);
        #1;
        drive_ap(idle_x());
        hwdata = 32'hBAD0BAD0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check32("post-reset s2 hreadyout", 32'(hro[2]), 32'd1);
        check32("post-reset s2 hresp", 32'(hresp_s[2]), 32'd0);
        @(posedge HCLK);
        #1;
        rd_q.delete();
        xf(2, 1'b0, 32'h30, 32'h0);
        xf(1, 1'b0, 32'h40, 32'h0);
        run_seq();
        check32("rd 0x30 after reset", rd_q[0], 32'h30303030);
        check32("s1 rd 0x40 retained", rd_q[1], 32'h1);

        // Random traffic: mixed slaves, sizes, idle/busy, deselects, out-of-window
        for (int n = 0; n < 300; n++) begin
            x.slv   = $urandom_range(0, NS - 1);
            x.sel   = ($urandom_range(0, 7) != 0);
            t       = $urandom_range(0, 7);
            x.trans = (t < 1) ? 2'd0 : ((t < 2) ? 2'd1 : ((t < 5) ? 2'd2 : 2'd3));
            x.write = $urandom_range(0, 1);
            x.size  = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a       = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 32'h10F));
            if ($urandom_range(0, 3) != 0 && x.size <= 3'd2) a = a & ~((32'd1 << x.size) - 32'd1);
            x.addr  = a;
            x.wdata = $urandom();
            x.burst = 3'($urandom_range(0, 7));
            seq_q.push_back(x);
        end
        run_seq();

        // Read everything back; the per-cycle compare checks each word
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < DEPTH / 4; w++) xf(s, 1'b0, 32'(4 * w), 32'h0);
        run_seq();
        repeat (2) @(posedge HCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Synthesizable AHB-Lite memory slave: the responder end of the bus driven by the team's AHB master simulation model.
- Holds a byte-addressable, little-endian memory window of DEPTH_IN_BYTES starting at START_ADDR.
- Services single and burst transfers with byte, halfword and word sizes, optional fixed wait states, and two-cycle ERROR responses.
- Sits behind the decoder/HSEL in the test system; memory-test bursts of up to 255 beats run against it.

Parameters:
- START_ADDR, 0, base byte address of the window.
- DEPTH_IN_BYTES, 32'h100, window size in bytes; multiple of 4.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per accepted OKAY transfer; range 0..3.

Ports:
- HCLK  input  1  bus clock; all logic on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address (address phase).
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  0=byte, 1=halfword, 2=word.
- HBURST  input  3  burst type; informational only.
- HWDATA  input  32  write data (data phase).
- HREADY  input  1  bus-wide ready (muxed HREADYOUT).
- HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase.
- HRESP  output  2  OKAY=0, ERROR=1.
- HREADYOUT  output  1  slave ready.

Behaviour:
- Reset (HRESET=1 at a clock edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons that transfer; a pending write is not committed.
- Accept: at an edge with HSEL & HREADY & HTRANS[1]=1, latch HADDR, HWRITE and HSIZE.
  - IDLE or BUSY transfers, or HSEL=0, are not accepted; they get a zero-wait OKAY data phase with no memory access.
- Error check at accept; ERROR if any of:
  - address < START_ADDR or address+size_bytes-1 > START_ADDR+DEPTH_IN_BYTES-1;
  - HSIZE>2;
  - address not aligned to its size.
- States:
  - IDLE: no data phase pending. HREADYOUT=1, HRESP=OKAY.
    - Accept with no error: WAIT if WAIT_STATES>0, else DATA.
    - Accept with error: ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter counts WAIT_STATES cycles, then DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY; final data-phase cycle.
    - A new accept in the same cycle re-enters WAIT, DATA or ERR1 directly (pipelined, no bubble).
    - Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR; next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Behaves like DATA for accepting the next transfer; no memory access.
- Write: committed at the edge ending the DATA cycle.
  - Byte enables from latched addr[1:0] and size:
    - byte: lane = addr[1:0];
    - halfword: lanes {1,0} if addr[1]=0, else {3,2};
    - word: all lanes.
  - Lane n takes HWDATA[8n+7:8n].
- Read: HRDATA is the full 32-bit word at latched addr[31:2] during a DATA cycle of a read; the master masks the lanes it needs.
  - HRDATA=0 in every other cycle.
  - A read immediately following a write to the same word returns the post-write value; the write commits before the read data phase.
- Bursts: the slave follows HADDR beat by beat and ignores HBURST for addressing.
  - Wrap and incrementing bursts are both served correctly.
  - A burst crossing the window end gets ERROR on the offending beat only.
- Wait states apply per beat, including SEQ beats.
- HREADY=0 from another slave blocks acceptance; the current state does not advance until own DATA.

Test Plan:
- Word write 0xDEADBEEF to 0x10, then word read 0x10 (WAIT_STATES=0) -> HRDATA=0xDEADBEEF on the data-phase cycle, HREADYOUT=1 throughout, HRESP=0.
- Word write 0x11223344 to 0x10, byte write HWDATA=0xA5000000 to 0x13, halfword write HWDATA=0x0000BEEF to 0x10, word read 0x10 -> 0xA522BEEF.
- Back-to-back pipelined write 0x20=0xCAFEF00D then read 0x20 with no idle between -> read returns 0xCAFEF00D.
- WAIT_STATES=2, INCR4 write 0x40..0x4C with 1,2,3,4, then INCR4 read -> each beat shows HREADYOUT low 2 cycles; reads return 1,2,3,4.
- Word access 0x100, halfword at 0x11, and HSIZE=3 -> each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory at 0xFC/0x10 unchanged on readback.
- WAIT_STATES=3, assert HRESET during the second wait cycle of a write to 0x30 -> next cycle HREADYOUT=1, HRESP=0; 0x30 keeps its prior value; other contents retained.
